// File: rtl/pht_ctrl.sv
// PHT controller: init sweep of 2**INDEX_WIDTH writes, then 3-stage read-modify-write counter updates
// (accept at T, table write at T+2); upd_rdy_o is low during the sweep and on an init request.
module pht_ctrl #(
  parameter int         INDEX_WIDTH = 8,
  parameter logic [1:0] INIT_STATE  = 2'b01,
  parameter int         CNT_WIDTH   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   init_req_i,
  output logic                   busy_o,
  input  logic                   upd_vld_i,
  input  logic [INDEX_WIDTH-1:0] upd_idx_i,
  input  logic                   upd_taken_i,
  output logic                   upd_rdy_o,
  output logic                   tbl_rd_en_o,
  output logic [INDEX_WIDTH-1:0] tbl_rd_idx_o,
  input  logic [1:0]             tbl_rd_data_i,
  output logic                   tbl_wr_en_o,
  output logic [INDEX_WIDTH-1:0] tbl_wr_idx_o,
  output logic [1:0]             tbl_wr_data_o,
  output logic [CNT_WIDTH-1:0]   upd_cnt_o
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;
  logic                   busy_q, busy_d;
  logic                   s1_vld_q, s1_vld_d;
  logic [INDEX_WIDTH-1:0] s1_idx_q, s1_idx_d;
  logic                   s1_taken_q, s1_taken_d;
  logic                   wr_en_q, wr_en_d;
  logic [INDEX_WIDTH-1:0] wr_idx_q, wr_idx_d;
  logic [1:0]             wr_data_q, wr_data_d;
  logic                   old_vld_q, old_vld_d;
  logic [INDEX_WIDTH-1:0] old_idx_q, old_idx_d;
  logic [1:0]             old_data_q, old_data_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic                   accept;
  logic [INDEX_WIDTH-1:0] widx;
  logic [1:0]             cur_val;
  logic [1:0]             new_val;

  assign upd_rdy_o    = (state_q == ST_RUN) && !init_req_i;
  assign accept       = upd_vld_i && upd_rdy_o;
  assign tbl_rd_en_o  = accept;
  assign tbl_rd_idx_o = upd_idx_i;

  assign busy_o        = busy_q;
  assign tbl_wr_en_o   = wr_en_q;
  assign tbl_wr_idx_o  = wr_idx_q;
  assign tbl_wr_data_o = wr_data_q;
  assign upd_cnt_o     = cnt_q;

  // The RAM has not yet committed the two most recent writes when stage 1 sees its read data.
  always_comb begin
    if (wr_en_q && (wr_idx_q == s1_idx_q)) begin
      cur_val = wr_data_q;
    end else if (old_vld_q && (old_idx_q == s1_idx_q)) begin
      cur_val = old_data_q;
    end else begin
      cur_val = tbl_rd_data_i;
    end
    if (s1_taken_q) begin
      new_val = (cur_val == 2'b11) ? 2'b11 : cur_val + 2'b01;
    end else begin
      new_val = (cur_val == 2'b00) ? 2'b00 : cur_val - 2'b01;
    end
  end

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    busy_d     = busy_q;
    s1_vld_d   = 1'b0;
    s1_idx_d   = s1_idx_q;
    s1_taken_d = s1_taken_q;
    wr_en_d    = 1'b0;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;
    old_vld_d  = wr_en_q;
    old_idx_d  = wr_idx_q;
    old_data_d = wr_data_q;
    cnt_d      = cnt_q;
    widx       = init_req_i ? '0 : sweep_q;

    case (state_q)
      ST_INIT: begin
        wr_en_d   = 1'b1;
        wr_idx_d  = widx;
        wr_data_d = INIT_STATE;
        sweep_d   = widx + 1'b1;
        if (widx == {INDEX_WIDTH{1'b1}}) begin
          state_d = ST_RUN;
          busy_d  = 1'b0;
        end
      end
      default: begin
        if (init_req_i) begin
          // Stage-1 update is dropped; the write already on tbl_wr_* still lands this edge.
          state_d   = ST_INIT;
          sweep_d   = '0;
          busy_d    = 1'b1;
          old_vld_d = 1'b0;
        end else begin
          s1_vld_d   = accept;
          s1_idx_d   = upd_idx_i;
          s1_taken_d = upd_taken_i;
          if (s1_vld_q) begin
            wr_en_d   = 1'b1;
            wr_idx_d  = s1_idx_q;
            wr_data_d = new_val;
            if (cnt_q != {CNT_WIDTH{1'b1}}) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_INIT;
      sweep_q    <= '0;
      busy_q     <= 1'b1;
      s1_vld_q   <= 1'b0;
      s1_idx_q   <= '0;
      s1_taken_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
      old_vld_q  <= 1'b0;
      old_idx_q  <= '0;
      old_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      busy_q     <= busy_d;
      s1_vld_q   <= s1_vld_d;
      s1_idx_q   <= s1_idx_d;
      s1_taken_q <= s1_taken_d;
      wr_en_q    <= wr_en_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
      old_vld_q  <= old_vld_d;
      old_idx_q  <= old_idx_d;
      old_data_q <= old_data_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pht_ctrl.sv
// Bench for pht_ctrl: directed scenarios then random traffic, checked against a
// counter-table reference model with a queue of expected table writes.
module tb_pht_ctrl;
  localparam int IW    = 4;
  localparam int DEPTH = 16;
  localparam int CW    = 4;
  localparam int CMAX  = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_req;
  logic          busy_o;
  logic          upd_vld;
  logic [IW-1:0] upd_idx;
  logic          upd_taken;
  logic          upd_rdy_o;
  logic          tbl_rd_en_o;
  logic [IW-1:0] tbl_rd_idx_o;
  logic [1:0]    tbl_rd_data;
  logic          tbl_wr_en_o;
  logic [IW-1:0] tbl_wr_idx_o;
  logic [1:0]    tbl_wr_data_o;
  logic [CW-1:0] upd_cnt_o;

  always #5 clk = ~clk;

  pht_ctrl #(.INDEX_WIDTH(IW), .INIT_STATE(2'b01), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .init_req_i(init_req), .busy_o(busy_o),
    .upd_vld_i(upd_vld), .upd_idx_i(upd_idx), .upd_taken_i(upd_taken), .upd_rdy_o(upd_rdy_o),
    .tbl_rd_en_o(tbl_rd_en_o), .tbl_rd_idx_o(tbl_rd_idx_o), .tbl_rd_data_i(tbl_rd_data),
    .tbl_wr_en_o(tbl_wr_en_o), .tbl_wr_idx_o(tbl_wr_idx_o), .tbl_wr_data_o(tbl_wr_data_o),
    .upd_cnt_o(upd_cnt_o)
  );

  // Table RAM: synchronous read-first, one-cycle read latency.
  logic [1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (tbl_rd_en_o) tbl_rd_data <= mem[tbl_rd_idx_o];
    if (tbl_wr_en_o) mem[tbl_wr_idx_o] <= tbl_wr_data_o;
  end

  typedef struct {int due; int idx; int data; bit upd;} wr_t;
  wr_t pend[$];
  int  ref_tbl [DEPTH];
  bit  m_run;
  int  m_sweep;
  int  exp_cnt;
  int  cyc;
  int  n_assert = 0;
  int  n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_run   = 1'b0;
    m_sweep = 0;
    exp_cnt = 0;
  endtask

  // One clock: check combinational outputs and advance the model before the edge,
  // then check registered outputs after it.
  task automatic tick();
    wr_t e;
    bit  acc;
    int  widx;
    int  nv;
    @(negedge clk);
    acc = m_run && !init_req && upd_vld;
    chk("upd_rdy", 32'(upd_rdy_o), 32'(m_run && !init_req));
    chk("rd_en", 32'(tbl_rd_en_o), 32'(acc));
    if (acc) chk("rd_idx", 32'(tbl_rd_idx_o), 32'(upd_idx));
    if (!m_run) begin
      widx = init_req ? 0 : m_sweep;
      e = '{cyc + 1, widx, 1, 1'b0};
      pend.push_back(e);
      ref_tbl[widx] = 1;
      m_sweep = widx + 1;
      if (widx == DEPTH - 1) m_run = 1'b1;
    end else if (init_req) begin
      m_run   = 1'b0;
      m_sweep = 0;
      for (int i = pend.size() - 1; i >= 0; i--)
        if (pend[i].due == cyc + 1) pend.delete(i);
    end else if (acc) begin
      if (upd_taken) nv = (ref_tbl[upd_idx] == 3) ? 3 : ref_tbl[upd_idx] + 1;
      else           nv = (ref_tbl[upd_idx] == 0) ? 0 : ref_tbl[upd_idx] - 1;
      ref_tbl[upd_idx] = nv;
      e = '{cyc + 2, int'(upd_idx), nv, 1'b1};
      pend.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      chk("wr_en", 32'(tbl_wr_en_o), 32'd1);
      chk("wr_idx", 32'(tbl_wr_idx_o), 32'(e.idx));
      chk("wr_data", 32'(tbl_wr_data_o), 32'(e.data));
      if (e.upd && exp_cnt < CMAX) exp_cnt++;
    end else begin
      chk("wr_en_idle", 32'(tbl_wr_en_o), 32'd0);
    end
    chk("busy", 32'(busy_o), 32'(!m_run));
    chk("upd_cnt", 32'(upd_cnt_o), 32'(exp_cnt));
  endtask

  task automatic check_reset_values();
    chk("rst_busy", 32'(busy_o), 32'd1);
    chk("rst_rdy", 32'(upd_rdy_o), 32'd0);
    chk("rst_rd_en", 32'(tbl_rd_en_o), 32'd0);
    chk("rst_wr_en", 32'(tbl_wr_en_o), 32'd0);
    chk("rst_wr_idx", 32'(tbl_wr_idx_o), 32'd0);
    chk("rst_wr_data", 32'(tbl_wr_data_o), 32'd0);
    chk("rst_cnt", 32'(upd_cnt_o), 32'd0);
  endtask

  task automatic upd(input int idx, input bit taken);
    upd_vld   = 1'b1;
    upd_idx   = IW'(idx);
    upd_taken = taken;
    tick();
  endtask

  task automatic idle(input int n);
    upd_vld  = 1'b0;
    init_req = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    init_req  = 1'b0;
    upd_vld   = 1'b0;
    upd_idx   = '0;
    upd_taken = 1'b0;
    cyc       = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;

    // Sweep of 16 writes, then idle run cycles.
    idle(18);

    // Single taken update to idx 5.
    upd(5, 1'b1);
    idle(3);

    // Back-to-back taken updates to idx 3: saturation and current-write forwarding.
    for (int i = 0; i < 4; i++) upd(3, 1'b1);
    idle(3);

    // Interleaved not-taken updates to idx 7: floor and one-older forwarding.
    upd(7, 1'b0);
    upd(9, 1'b1);
    upd(7, 1'b0);
    upd(7, 1'b0);
    idle(3);

    // Init request the cycle after an accept squashes that update.
    upd(2, 1'b1);
    init_req = 1'b1;
    upd_vld  = 1'b1;
    tick();
    init_req = 1'b0;
    upd_vld  = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    idle(2);

    // Asynchronous reset in the middle of a sweep.
    init_req = 1'b1;
    upd_vld  = 1'b0;
    tick();
    init_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(18);

    // Random traffic over a few hot indices.
    for (int i = 0; i < 500; i++) begin
      upd_vld   = ($urandom_range(0, 3) != 0);
      upd_idx   = IW'($urandom_range(0, 3) + (($urandom_range(0, 7) == 0) ? 8 : 0));
      upd_taken = $urandom_range(0, 1) == 1;
      init_req  = ($urandom_range(0, 59) == 0);
      tick();
    end
    idle(20);

    for (int i = 0; i < DEPTH; i++) chk($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(ref_tbl[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pht_ctrl.md
Name: pht_ctrl

Overview:
- Controller for the 2-bit saturating-counter pattern history table (PHT) shared by the two_bit, gshare and agree predictor variants.
- Owns the table's single write port and its update-path read port.
- Runs a full-table initialisation sweep after reset or on request. Afterwards it performs pipelined read-modify-write counter updates for branches resolved in EX/MEM.
- Sits between the EX/MEM branch-resolution logic and the external PHT RAM. The prediction read port in IF is not touched.

Parameters:
- INDEX_WIDTH, 8, PHT index width; table depth = 2**INDEX_WIDTH.
- INIT_STATE, 2'b01, counter value written by the init sweep (weakly not-taken).
- CNT_WIDTH, 32, width of the applied-update statistics counter.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- init_req_i  in  1  one-cycle pulse: reinitialise the whole table.
- busy_o  out  1  high while the init sweep is in progress.
- upd_vld_i  in  1  branch-resolution update valid.
- upd_idx_i  in  INDEX_WIDTH  PHT index of the resolved branch.
- upd_taken_i  in  1  actual branch outcome.
- upd_rdy_o  out  1  update accepted when upd_vld_i && upd_rdy_o.
- tbl_rd_en_o  out  1  table read enable.
- tbl_rd_idx_o  out  INDEX_WIDTH  table read index.
- tbl_rd_data_i  in  2  read data, valid 1 cycle after tbl_rd_en_o.
- tbl_wr_en_o  out  1  table write enable (registered).
- tbl_wr_idx_o  out  INDEX_WIDTH  table write index (registered).
- tbl_wr_data_o  out  2  table write data (registered).
- upd_cnt_o  out  CNT_WIDTH  number of counter updates written; saturates at all-ones.

Behaviour:
- Table contract:
  - Synchronous read, 1-cycle latency.
  - Read-first semantics: a same-cycle read and write to the same index returns the pre-write value.
- State machine has two states, INIT and RUN. Reset puts it in INIT with sweep index 0.
- Reset values:
  - busy_o=1, upd_rdy_o=0.
  - tbl_rd_en_o=0, tbl_wr_en_o=0, tbl_wr_idx_o=0, tbl_wr_data_o=0.
  - upd_cnt_o=0; all pipeline and forwarding valids cleared.
- INIT:
  - Each cycle registers one write: idx = sweep index, data = INIT_STATE.
  - The first write is visible on the first clock edge after rst_ni deasserts.
  - Sweep index 2**INDEX_WIDTH-1 is the last write; next state is RUN.
  - The sweep takes exactly 2**INDEX_WIDTH cycles. busy_o falls in the cycle after the last write is registered.
  - init_req_i during INIT restarts the sweep at index 0.
  - upd_rdy_o=0 throughout INIT.
- RUN:
  - upd_rdy_o = !init_req_i.
  - Stage 0 (cycle T): on accept, tbl_rd_en_o=1 and tbl_rd_idx_o=upd_idx_i (combinational); idx and taken are registered into stage 1.
  - Stage 1 (cycle T+1): compute the old value, then new = taken ? min(old+1,3) : max(old-1,0).
  - Stage 2: new value is registered onto tbl_wr_* (visible at T+2); upd_cnt_o increments at the same edge.
- Forwarding (old value in stage 1), in priority order:
  1. Current tbl_wr_* register, if tbl_wr_en_o is set and its idx matches.
  2. One-older write register, if valid and its idx matches.
  3. Otherwise tbl_rd_data_i.
- Forwarding makes back-to-back and every-other-cycle updates to the same index exact. The sustained rate is one update per cycle with no bubbles.
- init_req_i in RUN:
  - Next state is INIT with sweep index 0.
  - Any stage-1 update is squashed: no write, no count.
  - A write already in the tbl_wr_* register completes.
  - The forwarding registers are cleared.
- upd_vld_i with upd_rdy_o=0 is simply not accepted; the requester holds it.
- Asynchronous reset mid-sweep or mid-update returns all state to the reset values immediately, with no partial write.
- upd_cnt_o holds at 2**CNT_WIDTH-1 once reached.
- tbl_wr_en_o is 0 in any cycle with no scheduled write; tbl_rd_en_o is 0 when there is no accept.

Test Plan:
- Reset, INDEX_WIDTH=4 -> 16 consecutive writes, idx 0..15, data 2'b01; busy_o falls the cycle after idx 15; upd_rdy_o rises with it.
- Single update idx 5, taken, table holds 01 -> tbl_rd_en_o at T with idx 5; write idx 5, data 10 at T+2; upd_cnt_o=1.
- Four back-to-back taken updates to idx 3 from 01 -> writes 10, 11, 11, 11 on consecutive cycles (saturation and forwarding); upd_cnt_o=4.
- Alternating updates idx 7 not-taken, idx 9, idx 7 not-taken, idx 7 starting at 01 -> idx 7 writes 00, 00, 00 (floor saturation and one-older forwarding); idx 9 unaffected.
- init_req_i asserted the cycle after an update is accepted -> that update is never written; upd_cnt_o unchanged; full sweep of 16 writes follows; upd_rdy_o=0 throughout.
- rst_ni pulled low at sweep idx 6 -> outputs return to reset values at once; on release the sweep restarts at idx 0.
